// File: rtl/sha_mem_responder_if.sv
// Bundled engine memory bus and host request port seen by sha_mem_responder.
// The responder takes the slave modport; the engine/host side takes the master modport.
interface sha_mem_responder_if #(
  parameter int ADDR_W = 16
) ();
  // Engine memory bus: the responder answers every edge with a one-cycle read latency.
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  // Host port: a request transfers on any edge where host_valid && host_ready.
  // host_ready never depends on host_valid. A read answers with a one-cycle host_rvalid pulse.
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              host_rvalid;

  modport slave (
    input  mem_addr, mem_we, mem_write_data,
    output mem_read_data,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid
  );

  modport master (
    output mem_addr, mem_we, mem_write_data,
    input  mem_read_data,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid
  );
endinterface

// File: rtl/sha_mem_responder.sv
// Memory-side responder for the SHA-256 engine: a shared word SRAM, a host load/readback port,
// and a snoop that collects the eight digest words the engine writes at its output address.
module sha_mem_responder #(
  parameter int DEPTH         = 1024,
  parameter int ADDR_W        = 16,
  parameter int START_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              eng_start,
  input  logic              eng_done,
  input  logic [ADDR_W-1:0] digest_base,
  sha_mem_responder_if.slave bus,
  output logic [255:0]      digest,
  output logic              digest_valid,
  output logic              err,
  output logic [1:0]        state_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_HOST   = 2'd0,
    S_ARMED  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        mask_q;
  logic [255:0]      digest_q;
  logic              digest_valid_q;
  logic              err_q, err_d;
  logic              ready_en_q;
  logic [31:0]       mem_read_data_q;
  logic [31:0]       host_rdata_q;
  logic              host_rvalid_q;

  logic [31:0]       mem_q [DEPTH];

  logic              eng_active;
  logic              host_ready;
  logic              host_acc;
  logic              host_rd;
  logic              start_acc;
  logic              timeout;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [31:0]       sel_wdata;
  logic              sel_in_range;
  logic [31:0]       rd_data;
  logic [ADDR_W:0]   cap_off;
  logic              cap_hit;
  logic [2:0]        cap_word;

  assign eng_active = (state_q == S_ARMED) || (state_q == S_RUN);
  // ready_en_q keeps the host port closed for the first cycle after reset release.
  assign host_ready = ready_en_q && (state_q == S_HOST) && !eng_start;
  assign host_acc   = bus.host_valid && host_ready;
  assign host_rd    = host_acc && !bus.host_we;
  assign start_acc  = (state_q == S_HOST) && eng_start;
  assign timeout    = (state_q == S_ARMED) && eng_done && (cnt_q == CNT_W'(1));

  // The two ports are never live together, so one SRAM address path is shared.
  always_comb begin
    sel_addr  = bus.host_addr;
    sel_we    = host_acc && bus.host_we;
    sel_wdata = bus.host_wdata;
    if (eng_active) begin
      sel_addr  = bus.mem_addr;
      sel_we    = bus.mem_we;
      sel_wdata = bus.mem_write_data;
    end
  end

  assign sel_in_range = ({1'b0, sel_addr} < (ADDR_W + 1)'(DEPTH));
  assign rd_data      = sel_in_range ? mem_q[sel_addr[IDX_W-1:0]] : 32'd0;

  // One extra bit keeps the digest window from wrapping at the top of the address space.
  assign cap_off  = {1'b0, bus.mem_addr} - {1'b0, base_q};
  assign cap_hit  = (state_q == S_RUN) && bus.mem_we &&
                    ({1'b0, bus.mem_addr} >= {1'b0, base_q}) &&
                    (cap_off < (ADDR_W + 1)'(8));
  assign cap_word = 3'd7 - cap_off[2:0];

  always_comb begin
    err_d = err_q;
    if ((eng_active && !sel_in_range) || (host_acc && !sel_in_range) || timeout ||
        ((state_q == S_FINISH) && (mask_q != 8'hFF))) begin
      err_d = 1'b1;
    end
    if (start_acc) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sel_we && sel_in_range) begin
      mem_q[sel_addr[IDX_W-1:0]] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_HOST;
      cnt_q           <= '0;
      base_q          <= '0;
      mask_q          <= '0;
      digest_q        <= '0;
      digest_valid_q  <= 1'b0;
      err_q           <= 1'b0;
      ready_en_q      <= 1'b0;
      mem_read_data_q <= '0;
      host_rdata_q    <= '0;
      host_rvalid_q   <= 1'b0;
    end else begin
      ready_en_q     <= 1'b1;
      digest_valid_q <= 1'b0;
      err_q          <= err_d;
      host_rvalid_q  <= host_rd;
      if (host_rd) begin
        host_rdata_q <= rd_data;
      end
      if (eng_active) begin
        mem_read_data_q <= rd_data;
      end
      if (cap_hit) begin
        digest_q[{cap_word, 5'd0} +: 32] <= bus.mem_write_data;
        mask_q[cap_off[2:0]]             <= 1'b1;
      end
      case (state_q)
        S_HOST: begin
          if (eng_start) begin
            base_q  <= digest_base;
            mask_q  <= '0;
            cnt_q   <= CNT_W'(START_TIMEOUT);
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!eng_done) begin
            state_q <= S_RUN;
          end else if (cnt_q == CNT_W'(1)) begin
            state_q <= S_HOST;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RUN: begin
          if (eng_done) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          digest_valid_q <= (mask_q == 8'hFF);
          state_q        <= S_HOST;
        end
        default: state_q <= S_HOST;
      endcase
    end
  end

  assign bus.mem_read_data = mem_read_data_q;
  assign bus.host_ready    = host_ready;
  assign bus.host_rdata    = host_rdata_q;
  assign bus.host_rvalid   = host_rvalid_q;
  assign digest            = digest_q;
  assign digest_valid      = digest_valid_q;
  assign err               = err_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench for sha_mem_responder: host preload/readback, an emulated engine run,
// read latency, partial digest, out-of-range access, start timeout and mid-run reset.
module tb_sha_mem_responder;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         eng_start;
  logic         eng_done;
  logic [15:0]  digest_base;
  logic [255:0] digest;
  logic         digest_valid;
  logic         err;
  logic [1:0]   state_o;

  int total = 0;
  int bad   = 0;
  logic [31:0]  exp_q[$];
  logic [255:0] exp_dig;

  // SHA-256("abc"), h0 first.
  logic [31:0] golden [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  sha_mem_responder_if bus ();

  sha_mem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .digest_base  (digest_base),
    .bus          (bus),
    .digest       (digest),
    .digest_valid (digest_valid),
    .err          (err),
    .state_o      (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic host_wr(input logic [15:0] addr, input logic [31:0] data);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    tick();
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
  endtask

  task automatic host_rd(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = addr;
    tick();
    bus.host_valid = 1'b0;
    check({tag, "_rvalid"}, 256'(bus.host_rvalid), 256'(1));
    if (exp_q.size() > 0) begin
      check(tag, 256'(bus.host_rdata), 256'(exp_q.pop_front()));
    end
  endtask

  initial begin
    reset_n            = 1'b0;
    eng_start          = 1'b0;
    eng_done           = 1'b1;
    digest_base        = '0;
    bus.mem_addr       = '0;
    bus.mem_we         = 1'b0;
    bus.mem_write_data = '0;
    bus.host_valid     = 1'b0;
    bus.host_we        = 1'b0;
    bus.host_addr      = '0;
    bus.host_wdata     = '0;

    // reset state
    repeat (3) tick();
    check("rst_state", 256'(state_o), 256'(0));
    check("rst_ready", 256'(bus.host_ready), 256'(0));
    check("rst_rvalid", 256'(bus.host_rvalid), 256'(0));
    check("rst_rdata", 256'(bus.host_rdata), 256'(0));
    check("rst_mrdata", 256'(bus.mem_read_data), 256'(0));
    check("rst_digest", digest, 256'(0));
    check("rst_dvalid", 256'(digest_valid), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    reset_n = 1'b1;
    check("rel_ready0", 256'(bus.host_ready), 256'(0));
    tick();
    check("rel_ready1", 256'(bus.host_ready), 256'(1));

    // host preload and back-to-back readback
    for (int i = 0; i < 20; i++) host_wr(16'(i), 32'hDEAD0000 + 32'(i));
    host_wr(16'd30, 32'h0BADF00D);
    for (int i = 0; i < 20; i++) host_rd("preload_rd", 16'(i), 32'hDEAD0000 + 32'(i));
    tick();
    check("rvalid_idle", 256'(bus.host_rvalid), 256'(0));

    // engine run; host write to 30 is held pending and must never be accepted
    digest_base    = 16'h0100;
    eng_start      = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 16'd30;
    bus.host_wdata = 32'hFFFFFFFF;
    #1;
    check("arb_ready_start", 256'(bus.host_ready), 256'(0));
    tick();
    eng_start = 1'b0;
    #1;
    check("armed_state", 256'(state_o), 256'(1));
    check("armed_ready", 256'(bus.host_ready), 256'(0));
    eng_done     = 1'b0;
    bus.mem_addr = 16'd0;
    tick();
    check("run_state", 256'(state_o), 256'(2));
    check("run_ready", 256'(bus.host_ready), 256'(0));

    bus.mem_addr = 16'd5;
    tick();
    check("rd_latency", 256'(bus.mem_read_data), 256'(32'hDEAD0005));
    bus.mem_we         = 1'b1;
    bus.mem_write_data = 32'h12345678;
    tick();
    check("rd_old_on_wr", 256'(bus.mem_read_data), 256'(32'hDEAD0005));
    bus.mem_we = 1'b0;
    tick();
    check("rd_new", 256'(bus.mem_read_data), 256'(32'h12345678));

    // digest writes: a word to be overwritten, neighbours outside the window, then h7..h0
    bus.mem_we = 1'b1;
    bus.mem_addr = 16'h0100; bus.mem_write_data = 32'h55555555; tick();
    bus.mem_addr = 16'h0108; bus.mem_write_data = 32'h01080108; tick();
    bus.mem_addr = 16'h00FF; bus.mem_write_data = 32'h00FF00FF; tick();
    for (int i = 7; i >= 0; i--) begin
      bus.mem_addr       = 16'h0100 + 16'(i);
      bus.mem_write_data = golden[i];
      tick();
    end
    bus.mem_we = 1'b0;
    check("dvalid_early", 256'(digest_valid), 256'(0));
    eng_done       = 1'b1;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    tick();
    check("finish_state", 256'(state_o), 256'(3));
    check("finish_dvalid", 256'(digest_valid), 256'(0));
    tick();
    exp_dig = '0;
    for (int i = 0; i < 8; i++) exp_dig = {exp_dig[223:0], golden[i]};
    check("done_state", 256'(state_o), 256'(0));
    check("dvalid_pulse", 256'(digest_valid), 256'(1));
    check("digest", digest, exp_dig);
    check("run_err", 256'(err), 256'(0));
    bus.mem_addr = 16'd5;
    tick();
    check("dvalid_once", 256'(digest_valid), 256'(0));
    check("mrdata_hold", 256'(bus.mem_read_data), 256'(golden[0]));

    for (int i = 0; i < 8; i++) host_rd("digest_mem", 16'h0100 + 16'(i), golden[i]);
    host_rd("addr5", 16'd5, 32'h12345678);
    host_rd("blocked_wr", 16'd30, 32'h0BADF00D);
    host_rd("above_win", 16'h0108, 32'h01080108);
    host_rd("below_win", 16'h00FF, 32'h00FF00FF);

    // out-of-range host access
    check("oor_err_pre", 256'(err), 256'(0));
    host_wr(16'd1024, 32'hAAAAAAAA);
    check("oor_wr_err", 256'(err), 256'(1));
    host_rd("oor_rd", 16'd1024, 32'd0);
    host_rd("oor_no_alias", 16'd0, 32'hDEAD0000);

    // partial digest: only seven words written
    digest_base = 16'h0200;
    eng_start   = 1'b1;
    tick();
    eng_start = 1'b0;
    check("partial_err_clr", 256'(err), 256'(0));
    check("partial_armed", 256'(state_o), 256'(1));
    eng_done     = 1'b0;
    bus.mem_addr = 16'h0200;
    tick();
    bus.mem_we = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.mem_addr       = 16'h0200 + 16'(i);
      bus.mem_write_data = 32'hC0DE0000 + 32'(i);
      tick();
    end
    bus.mem_we = 1'b0;
    eng_done   = 1'b1;
    tick();
    tick();
    exp_dig = '0;
    for (int i = 0; i < 7; i++) exp_dig = {exp_dig[223:0], 32'hC0DE0000 + 32'(i)};
    exp_dig = {exp_dig[223:0], golden[7]};
    check("partial_state", 256'(state_o), 256'(0));
    check("partial_dvalid", 256'(digest_valid), 256'(0));
    check("partial_err", 256'(err), 256'(1));
    check("partial_digest", digest, exp_dig);

    // start timeout: eng_done never drops
    eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
    check("to_err_clr", 256'(err), 256'(0));
    repeat (14) tick();
    check("to_still_armed", 256'(state_o), 256'(1));
    tick();
    check("to_state", 256'(state_o), 256'(0));
    check("to_err", 256'(err), 256'(1));

    // asynchronous reset in the middle of a run
    eng_start = 1'b1;
    tick();
    eng_start    = 1'b0;
    eng_done     = 1'b0;
    bus.mem_addr = 16'h0200;
    tick();
    check("mr_run", 256'(state_o), 256'(2));
    bus.mem_we         = 1'b1;
    bus.mem_write_data = 32'h00000077;
    tick();
    bus.mem_we = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("mr_state", 256'(state_o), 256'(0));
    check("mr_digest", digest, 256'(0));
    check("mr_mrdata", 256'(bus.mem_read_data), 256'(0));
    check("mr_ready", 256'(bus.host_ready), 256'(0));
    check("mr_err", 256'(err), 256'(0));
    eng_done = 1'b1;
    tick();
    reset_n = 1'b1;
    check("mr_rel_ready0", 256'(bus.host_ready), 256'(0));
    tick();
    check("mr_rel_ready1", 256'(bus.host_ready), 256'(1));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
Memory-side responder for the SHA-256 engine's word-addressed memory bus (mem_addr/mem_we/mem_write_data/mem_read_data). It holds a DEPTH-word SRAM that serves the engine's message reads and digest writes. A host port preloads message words and reads memory back when the engine is not running. A capture unit snoops the engine's digest writes and presents the 256-bit hash with a valid pulse at end of run.

Parameters:
DEPTH, 1024, number of 32-bit words; addresses >= DEPTH are out of range
ADDR_W, 16, address width on both ports
START_TIMEOUT, 15, maximum cycles allowed in ARMED for the engine to drop done

Ports:
clk  in  1  clock; also drives the engine's mem_clk
reset_n  in  1  asynchronous active-low reset
eng_start  in  1  copy of the engine's start strobe
eng_done  in  1  engine done level (high while the engine is idle)
digest_base  in  ADDR_W  engine output_addr; sampled on eng_start
mem_addr  in  ADDR_W  engine word address
mem_we  in  1  engine write enable
mem_write_data  in  32  engine write data
mem_read_data  out  32  read data returned to the engine
host_valid  in  1  host request valid
host_ready  out  1  host request accepted when host_valid && host_ready
host_we  in  1  host write (1) or read (0)
host_addr  in  ADDR_W  host word address
host_wdata  in  32  host write data
host_rdata  out  32  host read data
host_rvalid  out  1  host_rdata valid (one-cycle pulse)
digest  out  256  {h0..h7}; h0 in bits [255:224]
digest_valid  out  1  one-cycle pulse: all 8 digest words captured
err  out  1  sticky: out-of-range access, missing digest words or start timeout; cleared on eng_start

Behaviour:
- Reset: state=HOST; mem_read_data=0, host_rdata=0, host_rvalid=0, host_ready=0, digest=0, digest_valid=0, err=0. SRAM contents are not reset.
- Engine port is active only in ARMED and RUN. At each posedge:
  - if mem_we: mem[mem_addr] <= mem_write_data;
  - mem_read_data <= mem[mem_addr], i.e. one-cycle read latency.
  - Read and write to the same address in the same cycle returns the old data.
  - In HOST and FINISH, engine writes are dropped and mem_read_data holds its value.
- Host port:
  - host_ready = (state==HOST) && !eng_start.
  - Accepted write updates the SRAM at that edge.
  - Accepted read drives host_rdata = mem[host_addr] with host_rvalid=1 on the next cycle; host_rvalid is 0 otherwise.
  - No pipelining limits: one request per cycle is allowed.
- Out of range (address >= DEPTH) on either port:
  - write is dropped; read returns 0;
  - err is set. For the host port, err is set only on an accepted request.
- FSM:
  - HOST: on eng_start, latch digest_base, clear the capture mask and err, load the timeout counter, go to ARMED. eng_start has priority over a simultaneous host request, which is not accepted.
  - ARMED: if eng_done==0, go to RUN. If the counter expires first, set err and go to HOST.
  - RUN: if eng_done==1, go to FINISH.
  - FINISH (1 cycle): if mask==8'hFF, pulse digest_valid; else set err. Then go to HOST.
- Capture:
  - In RUN, an engine write with digest_base <= mem_addr <= digest_base+7 stores the data in word (mem_addr-digest_base) and sets that mask bit.
  - Rewrites overwrite the word; the mask bit stays set.
  - Range arithmetic is ADDR_W+1 bits wide so the window does not wrap.
  - digest holds its value until the next capture write.
- eng_start during ARMED or RUN is ignored.
- Async reset mid-run returns to HOST immediately; partial captures are discarded.

Test Plan:
- Host preload and readback: host writes 0xDEAD0000+i to addresses 0..19, then reads 0..19 -> host_rdata matches on each host_rvalid, one cycle after acceptance.
- Full run against the SHA-256 engine: host loads the 20-word message, pulses eng_start with digest_base=0x100 -> after eng_done rises, digest_valid pulses once, digest equals the golden SHA-256, and mem[0x100..0x107] match.
- Engine read latency: in RUN, mem_addr=5 at edge N -> mem_read_data=mem[5] after edge N. Same-cycle write 0x12345678 to addr 5 -> mem_read_data shows the old value, and the next read shows 0x12345678.
- Partial digest: the engine writes only 7 of the 8 digest words, then eng_done rises -> no digest_valid pulse, err=1. The next eng_start clears err.
- Arbitration and out-of-range access: host_valid held high with eng_start -> host_ready=0 that cycle and through RUN. Host write to addr 1024 -> dropped, err=1.
- Timeout and reset: eng_done held high after eng_start -> err=1 and state HOST after 15 cycles. Assert reset_n low mid-RUN -> outputs return to reset values and host_ready=1 the cycle after release.
